// File: rtl/nn_link_pkg.sv
// Shared opcode/state types and default port widths for the accelerator link master.
package nn_link_pkg;

  localparam int NN_MM_DEPTH = 16;
  localparam int NN_MM_SIZE  = 16;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_WAIT  = 2'd2,
    OP_RSVD  = 2'd3
  } nn_link_op_t;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    RESP,
    WAIT
  } nn_link_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nn_link_master.sv
// Purpose: command-stream initiator driving the accelerator write/read port.
// Latency: write strobe 1 cycle after accept; read response READ_LATENCY+1 cycles after accept.
// Backpressure: cmd_ready low outside IDLE, writes stall on nn_busy, rsp held until rsp_ready; NN_LINK_TIMEOUT_EN adds a busy watchdog.
module nn_link_master
  import nn_link_pkg::*;
#(
  parameter int MM_DEPTH       = NN_MM_DEPTH,
  parameter int MM_SIZE        = NN_MM_SIZE,
  parameter int READ_LATENCY   = 1,
  parameter int WAIT_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [MM_DEPTH-1:0] cmd_addr,
  input  logic [MM_SIZE-1:0]  cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [MM_DEPTH-1:0] rsp_addr,
  output logic [MM_SIZE-1:0]  rsp_data,
  output logic                nn_write_enable,
  output logic [MM_DEPTH-1:0] nn_write_addr,
  output logic [MM_SIZE-1:0]  nn_write_data,
  input  logic                nn_busy,
  output logic [MM_DEPTH-1:0] nn_read_addr,
  input  logic [MM_SIZE-1:0]  nn_read_data,
  output logic                idle,
  output logic                error
);

  // One down-counter serves read latency, wait count and busy watchdog.
  localparam int CNT_W = max_int(WAIT_WIDTH,
                                 max_int($clog2(TIMEOUT_CYCLES + 1), $clog2(READ_LATENCY + 1)));
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  nn_link_op_t    op;
  nn_link_state_t state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MM_DEPTH-1:0] addr_q, rd_addr_q, rsp_addr_q;
  logic [MM_SIZE-1:0]  data_q, rsp_data_q;
  logic                latch_cmd;
  logic                capture;
  logic                timeout;

  assign op = nn_link_op_t'(cmd_op);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    latch_cmd       = 1'b0;
    capture         = 1'b0;
    timeout         = 1'b0;
    cmd_ready       = 1'b0;
    nn_write_enable = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          latch_cmd = 1'b1;
          case (op)
            OP_WRITE: begin
              state_d = WRITE;
`ifdef NN_LINK_TIMEOUT_EN
              cnt_d   = CNT_W'(TIMEOUT_CYCLES);
`endif
            end
            OP_READ: begin
              state_d = READ;
              cnt_d   = CNT_W'(READ_LATENCY);
            end
            OP_WAIT: begin
              state_d = WAIT;
              cnt_d   = CNT_W'(cmd_data[WAIT_WIDTH-1:0]);
            end
            default: ;
          endcase
        end
      end
      WRITE: begin
        if (!nn_busy) begin
          nn_write_enable = 1'b1;
          state_d         = IDLE;
        end
`ifdef NN_LINK_TIMEOUT_EN
        else if (cnt_q == CNT_ONE) begin
          // Watchdog expired: drop the write without a strobe.
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
`endif
      end
      READ: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      WAIT: begin
        // A zero count still costs one cycle, same as a count of one.
        if (cnt_q <= CNT_ONE) state_d = IDLE;
        else                  cnt_d   = cnt_q - CNT_ONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rd_addr_q  <= '0;
      rsp_addr_q <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_cmd) begin
        addr_q <= cmd_addr;
        data_q <= cmd_data;
      end
      if (latch_cmd && op == OP_READ) rd_addr_q <= cmd_addr;
      if (capture) begin
        rsp_data_q <= nn_read_data;
        rsp_addr_q <= addr_q;
      end
    end
  end

`ifdef NN_LINK_TIMEOUT_EN
  logic error_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       error_q <= 1'b0;
    else if (timeout) error_q <= 1'b1;
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign rsp_valid     = (state_q == RESP);
  assign rsp_addr      = rsp_addr_q;
  assign rsp_data      = rsp_data_q;
  assign nn_write_addr = addr_q;
  assign nn_write_data = data_q;
  assign nn_read_addr  = rd_addr_q;
  assign idle          = (state_q == IDLE) && !rsp_valid;

endmodule

// File: tb/tb_nn_link_master.sv
// Self-checking bench for nn_link_master: directed timing scenarios plus a randomized command stream.
module tb_nn_link_master;
  import nn_link_pkg::*;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_addr;
  logic [15:0] rsp_data;
  logic        nn_write_enable;
  logic [15:0] nn_write_addr;
  logic [15:0] nn_write_data;
  logic        nn_busy;
  logic [15:0] nn_read_addr;
  logic [15:0] nn_read_data;
  logic        idle;
  logic        error;

  logic [15:0] mem [256];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Accelerator read port model: combinational lookup of the presented address.
  assign nn_read_data = mem[nn_read_addr[7:0]];

  nn_link_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .nn_write_enable(nn_write_enable), .nn_write_addr(nn_write_addr), .nn_write_data(nn_write_data),
    .nn_busy(nn_busy), .nn_read_addr(nn_read_addr), .nn_read_data(nn_read_data),
    .idle(idle), .error(error)
  );

  // Presents one command for a single accept edge; callers ensure cmd_ready is high.
  task issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d);
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task test_reset;
    #12;
    total++;
    if (rsp_valid !== 1'b0 || nn_write_enable !== 1'b0 || error !== 1'b0 ||
        nn_read_addr !== 16'h0 || rsp_data !== 16'h0 || nn_write_addr !== 16'h0) begin
      bad++;
      $display("FAIL rst_outputs: got rv=%b we=%b err=%b ra=%h rd=%h wa=%h, want all 0",
               rsp_valid, nn_write_enable, error, nn_read_addr, rsp_data, nn_write_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || idle !== 1'b1) begin
      bad++;
      $display("FAIL rst_idle: got ready=%b idle=%b, want 1 1", cmd_ready, idle);
    end
  endtask

  task test_write;
    nn_busy = 1'b0;
    issue(OP_WRITE, 16'h0005, 16'h1234);
    @(negedge clk);
    total++;
    if (nn_write_enable !== 1'b1 || nn_write_addr !== 16'h0005 || nn_write_data !== 16'h1234) begin
      bad++;
      $display("FAIL wr_strobe: got we=%b a=%h d=%h, want 1 0005 1234",
               nn_write_enable, nn_write_addr, nn_write_data);
    end
    @(negedge clk);
    total++;
    if (nn_write_enable !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL wr_single: got we=%b ready=%b, want 0 1", nn_write_enable, cmd_ready);
    end
  endtask

  task test_write_busy;
    int early;
    early = 0;
    nn_busy = 1'b1;
    issue(OP_WRITE, 16'h00C3, 16'hA55A);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (nn_write_enable !== 1'b0 || cmd_ready !== 1'b0) early++;
      @(posedge clk);
      #1;
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL wrb_stall: got %0d bad stall cycles, want 0", early);
    end
    nn_busy = 1'b0;
    @(negedge clk);
    total++;
    if (nn_write_enable !== 1'b1 || nn_write_addr !== 16'h00C3 || nn_write_data !== 16'hA55A) begin
      bad++;
      $display("FAIL wrb_strobe: got we=%b a=%h d=%h, want 1 00c3 a55a",
               nn_write_enable, nn_write_addr, nn_write_data);
    end
    @(negedge clk);
    total++;
    if (nn_write_enable !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL wrb_done: got we=%b ready=%b, want 0 1", nn_write_enable, cmd_ready);
    end
  endtask

  task test_read;
    int held_bad;
    held_bad = 0;
    mem[8'h03] = 16'hBEEF;
    rsp_ready  = 1'b0;
    issue(OP_READ, 16'h0003, 16'h0000);
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || nn_read_addr !== 16'h0003) begin
      bad++;
      $display("FAIL rd_c1: got rv=%b ra=%h, want 0 0003", rsp_valid, nn_read_addr);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rd_c2: got rv=%b, want 0", rsp_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF || rsp_addr !== 16'h0003 || idle !== 1'b0)
        held_bad++;
    end
    total++;
    if (held_bad != 0) begin
      bad++;
      $display("FAIL rd_hold: got %0d bad cycles (rv=%b d=%h a=%h), want 0",
               held_bad, rsp_valid, rsp_data, rsp_addr);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL rd_hs: got rv=%b, want 1", rsp_valid);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || idle !== 1'b1) begin
      bad++;
      $display("FAIL rd_clear: got rv=%b idle=%b, want 0 1", rsp_valid, idle);
    end
  endtask

  task test_wait;
    int n_tab   [2];
    int exp_tab [2];
    int lowc;
    int idle_bad;
    n_tab   = '{5, 0};
    exp_tab = '{5, 1};
    for (int k = 0; k < 2; k++) begin
      lowc     = 0;
      idle_bad = 0;
      issue(OP_WAIT, 16'h0000, 16'(n_tab[k]));
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (cmd_ready === 1'b1) break;
        lowc++;
        if (idle !== 1'b0) idle_bad++;
      end
      total++;
      if (lowc != exp_tab[k]) begin
        bad++;
        $display("FAIL wait_len: n=%0d got %0d busy cycles, want %0d", n_tab[k], lowc, exp_tab[k]);
      end
      total++;
      if (idle_bad != 0) begin
        bad++;
        $display("FAIL wait_idle: n=%0d got idle high %0d cycles, want 0", n_tab[k], idle_bad);
      end
    end
  endtask

  task test_timeout;
    int strobes;
    strobes = 0;
    nn_busy = 1'b1;
    issue(OP_WRITE, 16'h0077, 16'h7777);
`ifdef NN_LINK_TIMEOUT_EN
    for (int i = 1; i <= 1024; i++) begin
      @(negedge clk);
      if (nn_write_enable === 1'b1) strobes++;
    end
    total++;
    if (cmd_ready !== 1'b0 || error !== 1'b0) begin
      bad++;
      $display("FAIL tmo_before: got ready=%b err=%b, want 0 0", cmd_ready, error);
    end
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || error !== 1'b1 || strobes != 0) begin
      bad++;
      $display("FAIL tmo_fire: got ready=%b err=%b strobes=%0d, want 1 1 0", cmd_ready, error, strobes);
    end
    nn_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (nn_write_enable === 1'b1) strobes++;
    end
    total++;
    if (strobes != 0 || error !== 1'b1) begin
      bad++;
      $display("FAIL tmo_sticky: got strobes=%0d err=%b, want 0 1", strobes, error);
    end
`else
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk);
      if (nn_write_enable === 1'b1) strobes++;
    end
    total++;
    if (cmd_ready !== 1'b0 || idle !== 1'b0 || error !== 1'b0 || strobes != 0) begin
      bad++;
      $display("FAIL tmo_off: got ready=%b idle=%b err=%b strobes=%0d, want 0 0 0 0",
               cmd_ready, idle, error, strobes);
    end
    @(posedge clk);
    #1;
    nn_busy = 1'b0;
    @(negedge clk);
    total++;
    if (nn_write_enable !== 1'b1 || nn_write_addr !== 16'h0077) begin
      bad++;
      $display("FAIL tmo_late_wr: got we=%b a=%h, want 1 0077", nn_write_enable, nn_write_addr);
    end
    @(negedge clk);
`endif
  endtask

  task test_async_reset;
    int strobes;
    int g;
    strobes = 0;
    nn_busy = 1'b1;
    issue(OP_WRITE, 16'h00AA, 16'h5555);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1 || idle !== 1'b1 || nn_write_enable !== 1'b0 ||
        nn_write_addr !== 16'h0 || nn_write_data !== 16'h0 || error !== 1'b0) begin
      bad++;
      $display("FAIL arst_wr: got ready=%b idle=%b we=%b a=%h d=%h err=%b, want 1 1 0 0 0 0",
               cmd_ready, idle, nn_write_enable, nn_write_addr, nn_write_data, error);
    end
    @(negedge clk);
    reset   = 1'b1;
    nn_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (nn_write_enable === 1'b1) strobes++;
    end
    total++;
    if (strobes != 0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL arst_nostrobe: got strobes=%0d ready=%b, want 0 1", strobes, cmd_ready);
    end
    mem[8'h42] = 16'hA5C3;
    rsp_ready  = 1'b0;
    issue(OP_READ, 16'h0042, 16'h0000);
    g = 0;
    while (rsp_valid !== 1'b1 && g < 10) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'hA5C3) begin
      bad++;
      $display("FAIL arst_rsp_pre: got rv=%b d=%h, want 1 a5c3", rsp_valid, rsp_data);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_data !== 16'h0 || rsp_addr !== 16'h0 ||
        nn_read_addr !== 16'h0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL arst_rsp: got rv=%b d=%h a=%h ra=%h ready=%b, want 0 0 0 0 1",
               rsp_valid, rsp_data, rsp_addr, nn_read_addr, cmd_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || idle !== 1'b1) begin
      bad++;
      $display("FAIL arst_after: got rv=%b idle=%b, want 0 1", rsp_valid, idle);
    end
  endtask

  // Random command stream with random stalls; expected writes/reads are kept in order-preserving queues.
  task test_random;
    ent_t        wq[$];
    ent_t        rq[$];
    ent_t        e;
    logic        r;
    int          guard;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] d;
    bit          done;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 80; n++) begin
          op = 2'($urandom_range(0, 3));
          a  = 16'($urandom);
          d  = (op == OP_WAIT) ? 16'($urandom_range(0, 3)) : 16'($urandom);
          cmd_op    = op;
          cmd_addr  = a;
          cmd_data  = d;
          cmd_valid = 1'b1;
          r     = 1'b0;
          guard = 0;
          while (!r && guard < 200) begin
            @(negedge clk);
            r = cmd_ready;
            @(posedge clk);
            #1;
            guard++;
          end
          cmd_valid = 1'b0;
          total++;
          if (r !== 1'b1) begin
            bad++;
            $display("FAIL rnd_accept: cmd %0d not accepted within %0d cycles", n, guard);
          end else if (op == OP_WRITE) begin
            wq.push_back('{a, d});
          end else if (op == OP_READ) begin
            rq.push_back('{a, mem[a[7:0]]});
          end
        end
        guard = 0;
        while ((wq.size() != 0 || rq.size() != 0) && guard < 200) begin
          @(negedge clk);
          guard++;
        end
        total++;
        if (wq.size() != 0 || rq.size() != 0) begin
          bad++;
          $display("FAIL rnd_drain: got %0d writes %0d reads outstanding, want 0 0", wq.size(), rq.size());
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          nn_busy   = ($urandom_range(0, 2) == 0);
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (nn_write_enable === 1'b1) begin
            total++;
            if (wq.size() == 0) begin
              bad++;
              $display("FAIL rnd_wr: got unexpected strobe a=%h d=%h, want none", nn_write_addr, nn_write_data);
            end else begin
              e = wq.pop_front();
              if (nn_write_addr !== e.a || nn_write_data !== e.d || nn_busy !== 1'b0) begin
                bad++;
                $display("FAIL rnd_wr: got a=%h d=%h busy=%b, want a=%h d=%h busy=0",
                         nn_write_addr, nn_write_data, nn_busy, e.a, e.d);
              end
            end
          end
          if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            total++;
            if (rq.size() == 0) begin
              bad++;
              $display("FAIL rnd_rd: got unexpected response a=%h d=%h, want none", rsp_addr, rsp_data);
            end else begin
              e = rq.pop_front();
              if (rsp_addr !== e.a || rsp_data !== e.d) begin
                bad++;
                $display("FAIL rnd_rd: got a=%h d=%h, want a=%h d=%h", rsp_addr, rsp_data, e.a, e.d);
              end
            end
          end
        end
      end
    join
  endtask

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_addr  = 16'h0;
    cmd_data  = 16'h0;
    rsp_ready = 1'b0;
    nn_busy   = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    test_reset();
    test_write();
    test_write_busy();
    test_read();
    test_wait();
    test_timeout();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
